// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB bus bundle for the memory slave.
// Ports (as modport signals): psel/penable/pwrite/paddr/pwdata/pstrb driven by
// the master; prdata/pready/pslverr driven by the slave.
interface apb_mem_slave_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: parametrised memory-backed APB slave with byte strobes,
// configurable wait states and an error response for out-of-range words.
// Ports: clk (rising edge), rst_n (async active-low), bus (apb_mem_slave_if.slave).
// Optional: define APB_MEM_SLAVE_PROT_CHK_EN to flag paddr/pwrite/penable
// changes during the access phase as an error response.
module apb_mem_slave #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic            clk,
  input logic            rst_n,
  apb_mem_slave_if.slave bus
);
  localparam int SW = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_wcnt;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic          r_pready, r_pslverr;
  logic [DW-1:0] r_prdata;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_setup, w_done, w_load, w_wr, w_err, w_viol;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_setup ? (WAIT_CYCLES == 0 ? S_READY : S_WAIT) : S_IDLE;
      S_WAIT:  w_next = !bus.psel ? S_IDLE : (r_wcnt == 4'd1 ? S_READY : S_WAIT);
      default: w_next = (!bus.psel || bus.penable) ? S_IDLE : S_READY;
    endcase
  end
  // In IDLE the response is formed from the live setup-phase bus; afterwards
  // from the values latched at setup.
  assign w_setup = bus.psel && !bus.penable;
  assign w_done  = r_state == S_READY && bus.psel && bus.penable;
  assign w_load  = r_state != S_READY && w_next == S_READY;
  assign w_addr  = r_state == S_IDLE ? bus.paddr : r_addr;
  assign w_wr    = r_state == S_IDLE ? bus.pwrite : r_write;
  assign w_err   = {1'b0, w_addr} >= DEPTH_W;
  assign w_rdata = (!w_wr && !w_err && !w_viol) ? r_mem[w_addr] : '0;
`ifdef APB_MEM_SLAVE_PROT_CHK_EN
  logic r_viol;
  logic w_viol_now;
  assign w_viol_now = r_state != S_IDLE && bus.psel &&
                      (bus.paddr != r_addr || bus.pwrite != r_write || !bus.penable);
  assign w_viol = r_viol || w_viol_now;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_viol <= 1'b0;
    else        r_viol <= w_next == S_IDLE ? 1'b0 : w_viol;
`else
  assign w_viol = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_setup) begin
        r_addr  <= bus.paddr;
        r_write <= bus.pwrite;
      end
      r_wcnt    <= r_state == S_WAIT ? r_wcnt - 4'd1 : 4'(WAIT_CYCLES);
      r_pready  <= w_load || (r_pready && w_next == S_READY);
      r_pslverr <= w_load ? (w_err || w_viol)
                          : w_next == S_READY && (r_pslverr || (r_state == S_READY && w_viol));
      r_prdata  <= w_load ? w_rdata : (w_next == S_READY && !w_viol) ? r_prdata : '0;
    end
  end
  always_ff @(posedge clk)
    if (w_done && r_write && !w_err && !w_viol)
      for (int i = 0; i < SW; i++)
        if (bus.pstrb[i]) r_mem[r_addr][8*i +: 8] <= bus.pwdata[8*i +: 8];
  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised memory-backed bus slave, successor to the fixed 256x32 slave: configurable data width, depth, and wait states. Adds byte strobes, a ready handshake and an error response. Sits on the peripheral side of the bus fabric as a scratchpad/mailbox target for the CPU cluster.

Parameters:
AW, 8, address width in words (paddr indexes words)
DW, 32, data width; multiple of 8, 8..64
DEPTH, 256, number of words; DEPTH <= 2**AW
WAIT_CYCLES, 0, wait states inserted per access, 0..15

Ports:
clk  in  1  bus clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
psel  in  1  slave select
penable  in  1  access phase indicator
pwrite  in  1  1 = write, 0 = read
paddr  in  AW  word address
pwdata  in  DW  write data
pstrb  in  DW/8  byte write strobes
prdata  out  DW  read data, valid only while pready=1 on a read
pready  out  1  transfer completes on edge where psel&penable&pready
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wcnt=0, pready=0, pslverr=0, prdata=0. Memory contents not reset.
- All outputs registered.
- FSM states: IDLE, WAIT, READY.
- IDLE: on edge with psel=1 & penable=0 (setup), latch pwrite, paddr, and err = (paddr >= DEPTH).
  - WAIT_CYCLES=0: go READY; pready<=1; pslverr<=err; prdata<=(read & !err) ? mem[paddr] : 0.
  - Otherwise: go WAIT; wcnt<=WAIT_CYCLES.
- WAIT: each edge wcnt<=wcnt-1. When wcnt==1: go READY, load pready/pslverr/prdata as above.
- READY: on edge with psel&penable, the transfer completes.
  - Write with !err: for each byte i with pstrb[i]=1, mem[addr][8i+7:8i]<=pwdata byte i. Bytes with strobe 0 unchanged.
  - pready<=0, pslverr<=0, prdata<=0; go IDLE.
- Latency: access phase lasts WAIT_CYCLES+1 cycles. Zero-wait is the classic 2-cycle setup/access transfer.
- Back-to-back: a setup may follow in the cycle after completion; no idle cycle required.
- Abort: psel=0 in WAIT or READY -> go IDLE, clear pready/pslverr/prdata, no memory write.
- Error access: pready still asserted after the wait states. Write discarded; prdata=0.
- Read uses the address latched at setup. paddr/pwrite changes during access are ignored (protocol violation, see optional feature).
- psel&penable seen in IDLE with no prior setup: ignored, stays IDLE.
- Reset mid-transfer: immediate return to reset values; any pending write is lost.

Optional Feature:
APB_MEM_SLAVE_PROT_CHK_EN
- Defined: during WAIT/READY, each edge compares paddr and pwrite to the latched values and checks penable=1 with psel=1. A mismatch sets a sticky violation flag for the transfer. At READY the response has pslverr=1, the write is suppressed and prdata=0. The flag clears on completion/abort.
- Undefined: no checking; live paddr/pwrite are ignored as described above. No extra flops.

Test Plan:
- Default params, write addr 0x10 data 0xDEADBEEF pstrb=0xF, then read 0x10 -> pready high in 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- Write 0x10 data 0x11223344 pstrb=0x5 over 0xDEADBEEF, read back -> prdata=0xDE22BE44.
- DEPTH=200: write 0xC8 data 0x1, read 0xC8 -> pslverr=1 with pready on both; prdata=0; a read of 0xC7 is unaffected.
- WAIT_CYCLES=3: read -> pready=0 for 3 access cycles, =1 on the 4th; prdata valid only then.
- Abort: drop psel during WAIT of a write to 0x20 -> FSM IDLE next cycle; 0x20 keeps its old value. rst_n low mid-READY -> pready/prdata=0 asynchronously.
- With APB_MEM_SLAVE_PROT_CHK_EN and WAIT_CYCLES=2: change paddr mid-write -> pslverr=1, memory unchanged. Without the macro -> write lands at the setup-phase address.
